instruction_fetch: RTL

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/instruction_fetch_pkg.sv | 30 +++
 rtl/instruction_fetch.sv | 119 +++++++++++
 2 files changed

// File: rtl/instruction_fetch_pkg.sv
// Shared CPU definitions: opcode field location, ALU/control opcodes, the NOP
// encoding and the fetch FSM state type.
package instruction_fetch_pkg;

  localparam int OPC_W   = 7;
  localparam int OPC_MSB = 6;
  localparam int OPC_LSB = 0;

  localparam logic [OPC_W-1:0] OPC_NOP      = 7'h00;
  localparam logic [OPC_W-1:0] OPC_LOAD_IMM = 7'h01;
  localparam logic [OPC_W-1:0] OPC_ADD      = 7'h02;
  localparam logic [OPC_W-1:0] OPC_SUB      = 7'h03;
  localparam logic [OPC_W-1:0] OPC_AND      = 7'h04;
  localparam logic [OPC_W-1:0] OPC_OR       = 7'h05;
  localparam logic [OPC_W-1:0] OPC_XOR      = 7'h06;
  localparam logic [OPC_W-1:0] OPC_HALT     = 7'b1010101;

  // All-zero word decodes as NOP, which is also what memory returns after reset.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } fetch_state_t;

  function automatic logic [OPC_W-1:0] opcode_of(input logic [31:0] word);
    return word[OPC_MSB:OPC_LSB];
  endfunction

endpackage

// File: rtl/instruction_fetch.sv
// Instruction fetch stage in front of a program memory with a registered
// 1-cycle read. Holds one word in flight, supports stall, redirect and HALT.
//
//   state   | meaning
//   ST_RUN  | fetching sequentially, honouring stall and redirect
//   ST_HALT | HALT word captured; present it until consumed, then stop
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int               ADDR_W   = 5,
  parameter int               DATA_W   = 32,
  parameter logic [OPC_W-1:0] HALT_OPC = OPC_HALT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] instruction,
  output logic [DATA_W-1:0] instr_out,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  output logic              halted,
  output logic [7:0]        instr_count
);

  fetch_state_t      state, state_next;
  logic [ADDR_W-1:0] pc, pc_next;
  logic              inflight_valid, inflight_valid_next;
  logic [ADDR_W-1:0] inflight_pc, inflight_pc_next;
  logic [DATA_W-1:0] instr_out_next;
  logic [ADDR_W-1:0] instr_pc_next;
  logic              instr_valid_next;
  logic              halted_next;
  logic [7:0]        instr_count_next;
  logic              consume;
  logic              halt_hit;

  // During a stall, re-read the in-flight word so the memory output stays put.
  assign prog_addr = (stall && inflight_valid) ? inflight_pc : pc;

  assign consume  = instr_valid && !stall;
  assign halt_hit = inflight_valid && (instruction[OPC_MSB:OPC_LSB] == HALT_OPC);

  // State and datapath registers; reset restarts fetch from address 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_RUN;
      pc             <= '0;
      inflight_valid <= 1'b0;
      inflight_pc    <= '0;
      instr_out      <= '0;
      instr_pc       <= '0;
      instr_valid    <= 1'b0;
      halted         <= 1'b0;
      instr_count    <= '0;
    end else begin
      state          <= state_next;
      pc             <= pc_next;
      inflight_valid <= inflight_valid_next;
      inflight_pc    <= inflight_pc_next;
      instr_out      <= instr_out_next;
      instr_pc       <= instr_pc_next;
      instr_valid    <= instr_valid_next;
      halted         <= halted_next;
      instr_count    <= instr_count_next;
    end
  end

  // Next-state and datapath updates; everything holds unless a rule fires.
  always_comb begin
    state_next          = state;
    pc_next             = pc;
    inflight_valid_next = inflight_valid;
    inflight_pc_next    = inflight_pc;
    instr_out_next      = instr_out;
    instr_pc_next       = instr_pc;
    instr_valid_next    = instr_valid;
    halted_next         = halted;
    instr_count_next    = instr_count;

    if (consume && (instr_count != 8'hff)) begin
      instr_count_next = instr_count + 8'd1;
    end

    case (state)
      ST_RUN: begin
        if (redirect_valid) begin
          // Redirect beats stall; the word in flight belongs to the old path.
          pc_next             = redirect_addr;
          inflight_valid_next = 1'b0;
          instr_valid_next    = 1'b0;
        end else if (!stall) begin
          instr_out_next   = instruction;
          instr_pc_next    = inflight_pc;
          instr_valid_next = inflight_valid;
          if (halt_hit) begin
            // Stop fetching: nothing behind the HALT may be presented.
            state_next          = ST_HALT;
            inflight_valid_next = 1'b0;
          end else begin
            inflight_valid_next = 1'b1;
            inflight_pc_next    = pc;
            pc_next             = pc + ADDR_W'(1);
          end
        end
      end
      ST_HALT: begin
        if (consume) begin
          instr_valid_next = 1'b0;
          halted_next      = 1'b1;
        end
      end
      default: state_next = ST_RUN;
    endcase
  end

endmodule
